// File: rtl/bayer_to_rgb.sv
// rtl/bayer_to_rgb.sv - GRBG Bayer demosaic with one-row line buffer and 2x2 window
module bayer_to_rgb #(
  parameter int num_cols     = 1280,
  parameter int num_rows     = 1024,
  parameter int num_bits_rgb = 12,
  localparam int x_w = $clog2(num_cols),
  localparam int y_w = $clog2(num_rows)
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  input  logic [num_bits_rgb-1:0] iraw_data,
  input  logic                    id_val,
  input  logic                    if_val,
  input  logic [x_w-1:0]          ix_pos,
  input  logic [y_w-1:0]          iy_pos,
  output logic [num_bits_rgb-1:0] ored,
  output logic [num_bits_rgb-1:0] ogreen,
  output logic [num_bits_rgb-1:0] oblue,
  output logic [x_w-1:0]          ox_pos,
  output logic [y_w-1:0]          oy_pos,
  output logic                    od_val,
  output logic                    of_val
);

  localparam int nb = num_bits_rgb;

  logic          accept;
  logic [nb-1:0] line_mem [num_cols];
  logic [nb-1:0] above_q;

  // stage 1: window of the pixel accepted on the previous cycle
  logic           s1_val;
  logic [x_w-1:0] s1_x;
  logic [y_w-1:0] s1_y;
  logic [nb-1:0]  s1_d;
  logic [nb-1:0]  s1_c;
  logic [nb-1:0]  prev_pix;
  logic [nb-1:0]  prev_above;
  logic           primed;
  logic           f_dly;

  logic [nb:0]    sum_ad;
  logic [nb:0]    sum_bc;
  logic [nb-1:0]  red_n;
  logic [nb-1:0]  green_n;
  logic [nb-1:0]  blue_n;
  logic           out_val;

  assign accept = id_val & if_val;

  // line buffer: read row y-1 at ix_pos, then overwrite with the current row
  always_ff @(posedge iclk) begin
    if (accept) begin
      above_q          <= line_mem[ix_pos];
      line_mem[ix_pos] <= iraw_data;
    end
  end

  // capture accepted pixel, left neighbour and previous above-pixel; gaps leave them alone
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s1_val     <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      s1_d       <= '0;
      s1_c       <= '0;
      prev_pix   <= '0;
      prev_above <= '0;
      primed     <= 1'b0;
      f_dly      <= 1'b0;
    end else begin
      s1_val <= accept;
      f_dly  <= if_val;
      if (accept) begin
        s1_x     <= ix_pos;
        s1_y     <= iy_pos;
        s1_d     <= iraw_data;
        s1_c     <= prev_pix;
        prev_pix <= iraw_data;
        if (ix_pos == '0 && iy_pos == '0) primed <= 1'b1;
      end
      // above_q of the pixel now in stage 1 becomes the A tap of the next pixel
      if (s1_val) prev_above <= above_q;
    end
  end

  assign sum_ad  = {1'b0, prev_above} + {1'b0, s1_d};
  assign sum_bc  = {1'b0, above_q} + {1'b0, s1_c};
  assign out_val = s1_val & primed & (s1_x != '0) & (s1_y != '0);

  // select R/G/B taps from the window by the GRBG site parity of the output pixel
  always_comb begin
    red_n   = '0;
    green_n = '0;
    blue_n  = '0;
    case ({s1_y[0], s1_x[0]})
      2'b11: begin red_n = above_q;    blue_n = s1_c;       green_n = sum_ad[nb:1]; end
      2'b10: begin red_n = prev_above; blue_n = s1_d;       green_n = sum_bc[nb:1]; end
      2'b01: begin red_n = s1_d;       blue_n = prev_above; green_n = sum_bc[nb:1]; end
      default: begin red_n = s1_c;     blue_n = above_q;    green_n = sum_ad[nb:1]; end
    endcase
  end

  // output register: colour and position hold when the pixel is suppressed
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ored   <= '0;
      ogreen <= '0;
      oblue  <= '0;
      ox_pos <= '0;
      oy_pos <= '0;
      od_val <= 1'b0;
      of_val <= 1'b0;
    end else begin
      od_val <= out_val;
      of_val <= f_dly;
      if (out_val) begin
        ored   <= red_n;
        ogreen <= green_n;
        oblue  <= blue_n;
        ox_pos <= s1_x;
        oy_pos <= s1_y;
      end
    end
  end

endmodule

// File: tb/tb_bayer_to_rgb.sv
// tb/tb_bayer_to_rgb.sv - randomized bench for bayer_to_rgb against a full-frame model
module tb_bayer_to_rgb;

  localparam int nc = 4;
  localparam int nr = 4;
  localparam int nb = 12;

  logic          iclk = 1'b0;
  logic          irst_n = 1'b1;
  logic [nb-1:0] iraw_data = '0;
  logic          id_val = 1'b0;
  logic          if_val = 1'b0;
  logic [1:0]    ix_pos = '0;
  logic [1:0]    iy_pos = '0;
  logic [nb-1:0] ored, ogreen, oblue;
  logic [1:0]    ox_pos, oy_pos;
  logic          od_val, of_val;

  always #5 iclk = ~iclk;

  bayer_to_rgb #(.num_cols(nc), .num_rows(nr), .num_bits_rgb(nb)) dut (
    .iclk(iclk), .irst_n(irst_n), .iraw_data(iraw_data), .id_val(id_val),
    .if_val(if_val), .ix_pos(ix_pos), .iy_pos(iy_pos), .ored(ored),
    .ogreen(ogreen), .oblue(oblue), .ox_pos(ox_pos), .oy_pos(oy_pos),
    .od_val(od_val), .of_val(of_val)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // model: image of accepted pixels, primed flag, expectation of the previous drive cycle
  int img [nr][nc];
  bit m_primed = 0;
  bit pv = 0, pf = 0;
  int pr = 0, pg = 0, pb = 0, px = 0, py = 0;
  int hr = 0, hg = 0, hb = 0, hx = 0, hy = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // GRBG site colour: 0=red, 1=green, 2=blue
  function automatic int site(input int x, input int y);
    if (y % 2 == 0) return (x % 2 == 0) ? 1 : 0;
    return (x % 2 == 0) ? 2 : 1;
  endfunction

  task automatic cyc(input bit dv, input bit fv, input int pix, input int x, input int y);
    bit nv;
    int r, g, b, gsum;
    nv = 0; r = 0; g = 0; b = 0; gsum = 0;
    id_val = dv; if_val = fv; iraw_data = pix[nb-1:0];
    ix_pos = x[1:0]; iy_pos = y[1:0];
    if (dv && fv) begin
      img[y][x] = pix;
      if (x == 0 && y == 0) m_primed = 1;
      if (m_primed && x > 0 && y > 0) begin
        nv = 1;
        for (int yy = y - 1; yy <= y; yy++)
          for (int xx = x - 1; xx <= x; xx++)
            case (site(xx, yy))
              0: r = img[yy][xx];
              2: b = img[yy][xx];
              default: gsum += img[yy][xx];
            endcase
        g = (gsum >> 1) & 32'hfff;
      end
    end
    @(posedge iclk);
    @(negedge iclk);
    if (pv) begin hr = pr; hg = pg; hb = pb; hx = px; hy = py; end
    if (od_val) pulses++;
    check("od_val", 32'(od_val), 32'(pv));
    check("of_val", 32'(of_val), 32'(pf));
    check("red", 32'(ored), hr);
    check("green", 32'(ogreen), hg);
    check("blue", 32'(oblue), hb);
    if (pv) begin
      check("x_pos", 32'(ox_pos), hx);
      check("y_pos", 32'(oy_pos), hy);
    end
    pv = nv; pf = fv; pr = r; pg = g; pb = b; px = x; py = y;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 4095),
          $urandom_range(0, nc - 1), $urandom_range(0, nr - 1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dval"}, 32'(od_val), 0);
    check({tag, "_fval"}, 32'(of_val), 0);
    check({tag, "_rgb"}, {8'd0, ored ^ ogreen ^ oblue} | 32'(ored), 0);
    check({tag, "_pos"}, 32'({ox_pos, oy_pos}), 0);
  endtask

  task automatic do_reset();
    @(negedge iclk);
    id_val = 1'b0; if_val = 1'b0;
    #2 irst_n = 1'b0;
    #1 check_zero("rst_async");
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    check_zero("rst_hold");
    irst_n = 1'b1;
    pv = 0; pf = 0; m_primed = 0;
    hr = 0; hg = 0; hb = 0; hx = 0; hy = 0;
  endtask

  function automatic int flat_pix(input int x, input int y, input int ge, input int go);
    case (site(x, y))
      0: return 200;
      2: return 300;
      default: return (y % 2 == 0) ? ge : go;
    endcase
  endfunction

  // kind 0: flat field with given greens; kind 1: random pixels with random gaps
  task automatic frame(input int kind, input int ge, input int go, input int y_start,
                       input int y_stop, input int x_stop);
    for (int y = y_start; y <= y_stop; y++)
      for (int x = 0; x < nc; x++) begin
        if (y == y_stop && x > x_stop) break;
        if (kind == 1) begin
          while ($urandom_range(0, 3) == 0)
            cyc(1'b0, 1'b1, $urandom_range(0, 4095), $urandom_range(0, nc - 1), y);
          if ($urandom_range(0, 7) == 0)
            cyc(1'b1, 1'b0, $urandom_range(0, 4095), x, y);
          cyc(1'b1, 1'b1, $urandom_range(0, 4095), x, y);
        end else begin
          cyc(1'b1, 1'b1, flat_pix(x, y, ge, go), x, y);
        end
      end
  endtask

  initial begin
    do_reset();
    idle(2);

    pulses = 0; frame(0, 100, 100, 0, nr - 1, nc - 1); idle(3);
    check("flat_pulses", pulses, 9);
    pulses = 0; frame(0, 101, 102, 0, nr - 1, nc - 1); idle(3);
    check("split_pulses", pulses, 9);
    frame(0, 4095, 4095, 0, nr - 1, nc - 1); idle(3);

    for (int f = 0; f < 8; f++) begin
      frame(1, 0, 0, 0, nr - 1, nc - 1);
      idle(2);
    end

    // reset during row 2, resume at row 3 without a new (0,0)
    frame(1, 0, 0, 0, 2, 1);
    do_reset();
    pulses = 0;
    frame(1, 0, 0, 3, 3, nc - 1);
    idle(3);
    check("post_reset_quiet", pulses, 0);
    pulses = 0;
    frame(1, 0, 0, 0, nr - 1, nc - 1);
    idle(3);
    check("post_reset_pulses", pulses, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bayer_to_rgb.md
Name: bayer_to_rgb

Overview:
Full-resolution Bayer demosaic stage between the CCD capture block and the greyscale stage. It accepts one raw GRBG pixel per valid cycle with its column and row coordinates. A one-row line buffer and a 2x2 window produce one RGB triple per input pixel at a fixed 2-cycle latency. Output RGB, coordinates and valid strobes drive the greyscale stage's red/green/blue, position and valid inputs directly.

Parameters:
num_cols, 1280, active pixels per row (line buffer depth)
num_rows, 1024, active rows per frame
num_bits_rgb, 12, raw and per-channel colour width

Ports:
iclk  in  1  pixel clock; all state on rising edge
irst_n  in  1  asynchronous active-low reset
iraw_data  in  num_bits_rgb  raw Bayer pixel
id_val  in  1  pixel valid; qualifies iraw_data, ix_pos, iy_pos
if_val  in  1  frame valid
ix_pos  in  clog2(num_cols)  column index of iraw_data, 0..num_cols-1
iy_pos  in  clog2(num_rows)  row index of iraw_data, 0..num_rows-1
ored  out  num_bits_rgb  red
ogreen  out  num_bits_rgb  green
oblue  out  num_bits_rgb  blue
ox_pos  out  clog2(num_cols)  column of output pixel
oy_pos  out  clog2(num_rows)  row of output pixel
od_val  out  1  output pixel valid
of_val  out  1  if_val delayed 2 cycles

Behaviour:
- Reset (async, irst_n=0): all outputs 0. Pipeline registers, previous-pixel registers and the primed flag are cleared. Line buffer contents are not reset.
- Accept: a pixel is accepted when id_val=1 and if_val=1. id_val while if_val=0 is ignored.
- Line buffer: num_cols x num_bits_rgb, read-before-write at address ix_pos. The read returns row y-1's pixel, then iraw_data is written. A synchronous-read RAM is permitted.
- Window for the pixel at (x,y): A=P[y-1][x-1], B=P[y-1][x], C=P[y][x-1], D=P[y][x].
  - A and C are held in previous-pixel registers that update only on accept.
  - Gaps in id_val do not disturb the window.
- Pattern: GRBG. Even rows are G R G R...; odd rows are B G B G...
- Colour mapping by (y[0], x[0]), where Gavg = (g1+g2)>>1 computed at num_bits_rgb+1 bits and then truncated:
  - odd,odd: R=B, Bl=C, G=avg(A,D)
  - odd,even: R=A, Bl=D, G=avg(B,C)
  - even,odd: R=D, Bl=A, G=avg(B,C)
  - even,even: R=C, Bl=B, G=avg(A,D)
- Latency: exactly 2 cycles from the accept cycle N to od_val/data at N+2, independent of gaps. ox_pos/oy_pos equal the accepted ix_pos/iy_pos.
- Edge suppression: od_val=0 for accepted pixels with x=0 or y=0. Colour outputs hold their last value when od_val=0.
- Primed flag:
  - Set on accepting pixel (0,0).
  - od_val is forced to 0 until it is set, so stale line-buffer data after a mid-frame reset is never emitted.
  - Once set, it stays set across frames until reset.
- of_val: a 2-stage delay of if_val, reset to 0. It is not gated by primed.
- Back-to-back accepts at one per cycle are sustained indefinitely. There is no stall output.
- Row wrap: ix_pos returning to 0 starts a new row. No internal column counter; coordinates are trusted.
- Reset asserted mid-operation: outputs drop to 0 asynchronously. In-flight pixels are discarded and never emitted.

Test Plan:
- Flat field, num_cols=4, num_rows=4. R sites=200, G=100, B=300. One frame of 16 back-to-back pixels -> 9 od_val pulses at (1..3,1..3), each R=200, G=100, B=300. of_val trails if_val by 2 cycles.
- Green split on the same frame: G on even rows=101, G on odd rows=102 -> every valid output G=101 (203>>1). No overflow at G=4095 on both -> G=4095.
- Latency with gaps: accept (1,1), idle 3 cycles, accept (2,1) -> od_val exactly 2 cycles after each accept. Window uses C=pixel (1,1), not idle-cycle data.
- Site mapping: unique values per pixel in a 4x4 frame -> each of the 4 parities selects A/B/C/D exactly per the colour-mapping table (check (1,1), (2,1), (1,2), (2,2)).
- Reset mid-frame: pulse irst_n low during row 2, then resume at row 3 -> all outputs 0 during reset. No od_val until pixel (0,0) of the next frame; the next frame then outputs 9 correct pixels.
- id_val=1 with if_val=0 -> no line-buffer write, no od_val, window unchanged.
